// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the ucaspian axon/synapse fire path.
package ucaspian_pkg;

  localparam int unsigned NEURON_W    = 8;
  localparam int unsigned SYN_W       = 10;
  localparam int unsigned COUNT_W     = 10;
  localparam int unsigned CFG_ENTRIES = 1 << NEURON_W;

  // cfg_byte codes; any other code is ignored
  localparam logic [2:0] CFG_BYTE_HI    = 3'd0;
  localparam logic [2:0] CFG_BYTE_START = 3'd1;
  localparam logic [2:0] CFG_BYTE_WRITE = 3'd2;

  typedef enum logic [1:0] {
    AX_IDLE,
    AX_LOOKUP,
    AX_SEND,
    AX_DISABLE
  } axon_state_e;

  typedef struct packed {
    logic [SYN_W-1:0]   start;
    logic [COUNT_W-1:0] count;
  } axon_cfg_t;

endpackage

// File: rtl/ucaspian_axon_fifo.sv
// Synchronous input FIFO of neuron ids; FIFO_DEPTH must be a power of two (>= 2).
module ucaspian_axon_fifo
  import ucaspian_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic [NEURON_W-1:0] push_data,
  input  logic                pop,
  output logic [NEURON_W-1:0] pop_data,
  output logic                empty,
  output logic                full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [NEURON_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]      wptr_q, rptr_q;
  logic                do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                    (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign pop_data = mem_q[rptr_q[PTR_W-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PTR_W+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/ucaspian_axon.sv
// Axon transmit: per-neuron synapse range lookup and syn_addr fan-out.
// Define UCASPIAN_AXON_FIFO_EN to place a FIFO_DEPTH-entry fire FIFO in front of the lookup.
module ucaspian_axon
  import ucaspian_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear_act,
  input  logic                clear_config,
  output logic                clear_done,
  output logic                step_done,
  input  logic [NEURON_W-1:0] cfg_addr,
  input  logic [7:0]          cfg_value,
  input  logic [2:0]          cfg_byte,
  input  logic                cfg_enable,
  input  logic [NEURON_W-1:0] axon_addr,
  input  logic                axon_vld,
  output logic                axon_rdy,
  output logic [SYN_W-1:0]    syn_addr,
  output logic                syn_vld,
  input  logic                syn_rdy
);

  axon_state_e state_q, state_d;

  axon_cfg_t cfg_mem [CFG_ENTRIES];
  axon_cfg_t rd_q;

  logic [SYN_W-1:0]    start_q, syn_addr_q;
  logic [COUNT_W-1:0]  count_q, offset_q;
  logic                syn_vld_q;
  logic                run_ok, fire_avail, fire_take, fifo_empty, last_xfer;
  logic [NEURON_W-1:0] fire_addr;

  logic [1:0]          hold_start_hi_q, hold_count_hi_q;
  logic [7:0]          hold_start_lo_q;
  logic [NEURON_W-1:0] clr_addr_q;
  logic                clr_walked_q, clear_done_q;

  logic                ram_we;
  logic [NEURON_W-1:0] ram_waddr;
  axon_cfg_t           ram_wdata;

  assign run_ok    = enable && !cfg_enable;
  assign last_xfer = (offset_q == count_q - COUNT_W'(1));

`ifdef UCASPIAN_AXON_FIFO_EN
  logic fifo_full, fifo_push;

  assign fifo_push  = axon_vld && axon_rdy;
  assign fire_avail = !fifo_empty;

  ucaspian_axon_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear_act),
    .push     (fifo_push),
    .push_data(axon_addr),
    .pop      (fire_take),
    .pop_data (fire_addr),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );
`else
  assign fifo_empty = 1'b1;
  assign fire_avail = axon_vld;
  assign fire_addr  = axon_addr;
`endif

  assign fire_take = (state_q == AX_IDLE) && run_ok && fire_avail && !clear_act && !reset;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= AX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AX_IDLE: begin
        if (!run_ok)         state_d = AX_DISABLE;
        else if (fire_avail) state_d = AX_LOOKUP;
      end
      AX_LOOKUP:  state_d = (rd_q.count == '0) ? AX_IDLE : AX_SEND;
      AX_SEND:    if (syn_rdy && last_xfer) state_d = AX_IDLE;
      AX_DISABLE: if (run_ok) state_d = AX_IDLE;
    endcase
    if (clear_act) state_d = AX_IDLE;
  end

  always_comb begin
    axon_rdy = 1'b0;
    if (!reset && !clear_act) begin
`ifdef UCASPIAN_AXON_FIFO_EN
      axon_rdy = run_ok && !fifo_full;
`else
      axon_rdy = run_ok && (state_q == AX_IDLE);
`endif
    end
    step_done = !reset && (state_q == AX_IDLE) && fifo_empty && !axon_vld;
  end

  // ---------------------------------------------------------------------------
  // Fan-out datapath: start/count are latched so mid-fire config writes do not leak in
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      syn_vld_q  <= 1'b0;
      syn_addr_q <= '0;
      start_q    <= '0;
      count_q    <= '0;
      offset_q   <= '0;
    end else if (clear_act) begin
      syn_vld_q <= 1'b0;
    end else begin
      case (state_q)
        AX_LOOKUP: begin
          start_q    <= rd_q.start;
          count_q    <= rd_q.count;
          offset_q   <= '0;
          syn_addr_q <= rd_q.start;
          syn_vld_q  <= (rd_q.count != '0);
        end
        AX_SEND: begin
          if (syn_vld_q && syn_rdy) begin
            if (last_xfer) begin
              syn_vld_q <= 1'b0;
            end else begin
              offset_q   <= offset_q + COUNT_W'(1);
              syn_addr_q <= start_q + offset_q + SYN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign syn_vld  = syn_vld_q;
  assign syn_addr = syn_addr_q;

  // ---------------------------------------------------------------------------
  // Configuration RAM: one write port, registered read (BRAM friendly)
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cfg_addr;
    ram_wdata = '{start: {hold_start_hi_q, hold_start_lo_q},
                  count: {hold_count_hi_q, cfg_value}};
    if (reset) begin
      ram_we = 1'b0;
    end else if (clear_config) begin
      ram_we    = !clr_walked_q;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end else if (cfg_enable && (cfg_byte == CFG_BYTE_WRITE)) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we)    cfg_mem[ram_waddr] <= ram_wdata;
    if (fire_take) rd_q <= cfg_mem[fire_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_start_hi_q <= '0;
      hold_count_hi_q <= '0;
      hold_start_lo_q <= '0;
    end else if (cfg_enable && !clear_config) begin
      case (cfg_byte)
        CFG_BYTE_HI: begin
          hold_start_hi_q <= cfg_value[1:0];
          hold_count_hi_q <= cfg_value[5:4];
        end
        CFG_BYTE_START: hold_start_lo_q <= cfg_value;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Clear walk and clear_done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr_q   <= '0;
      clr_walked_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      if (!clear_config) begin
        clr_addr_q   <= '0;
        clr_walked_q <= 1'b0;
      end else if (!clr_walked_q) begin
        clr_addr_q <= clr_addr_q + NEURON_W'(1);
        if (clr_addr_q == {NEURON_W{1'b1}}) clr_walked_q <= 1'b1;
      end
      clear_done_q <= clear_act ||
                      (clear_config && (clr_walked_q || (clr_addr_q == {NEURON_W{1'b1}})));
    end
  end

  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ucaspian_axon.sv
// Scoreboard bench for ucaspian_axon: a reference model expands each accepted fire
// into its synapse address list; a negedge monitor checks every syn transfer in order.
module tb_ucaspian_axon;
  import ucaspian_pkg::*;

`ifdef UCASPIAN_AXON_FIFO_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clear_act = 1'b0;
  logic       clear_config = 1'b0;
  logic       clear_done, step_done;
  logic [7:0] cfg_addr = '0;
  logic [7:0] cfg_value = '0;
  logic [2:0] cfg_byte = '0;
  logic       cfg_enable = 1'b0;
  logic [7:0] axon_addr = '0;
  logic       axon_vld = 1'b0;
  logic       axon_rdy;
  logic [9:0] syn_addr;
  logic       syn_vld;
  logic       syn_rdy;

  logic rand_rdy = 1'b0;
  logic rnd_bit = 1'b1;
  logic rdy_force = 1'b1;
  assign syn_rdy = rand_rdy ? rnd_bit : rdy_force;

  always #5 clk = ~clk;

  ucaspian_axon #(
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear_act   (clear_act),
    .clear_config(clear_config),
    .clear_done  (clear_done),
    .step_done   (step_done),
    .cfg_addr    (cfg_addr),
    .cfg_value   (cfg_value),
    .cfg_byte    (cfg_byte),
    .cfg_enable  (cfg_enable),
    .axon_addr   (axon_addr),
    .axon_vld    (axon_vld),
    .axon_rdy    (axon_rdy),
    .syn_addr    (syn_addr),
    .syn_vld     (syn_vld),
    .syn_rdy     (syn_rdy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int ref_start[256];
  int ref_count[256];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: in-order scoreboard plus stall-stability checks
  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic       prev_abort = 1'b1;
  logic [9:0] prev_addr = '0;
  int         last_xfer = -1;
  int         max_gap = 0;
  int         mon_exp;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_vld && !prev_rdy && !prev_abort) begin
        chk("stall_vld_held", int'(syn_vld), 1);
        chk("stall_addr_held", int'(syn_addr), int'(prev_addr));
      end
      if (syn_vld && syn_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_syn: got addr %0d, expected no transfer (cycle %0d)",
                   syn_addr, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("syn_addr_seq", int'(syn_addr), mon_exp);
        end
        if (last_xfer >= 0 && (cyc - last_xfer) > max_gap) max_gap = cyc - last_xfer;
        last_xfer = cyc;
      end
    end
    prev_vld   = syn_vld;
    prev_rdy   = syn_rdy;
    prev_addr  = syn_addr;
    prev_abort = reset || clear_act;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int n, input int s, input int c);
    cfg_addr   = n[7:0];
    cfg_enable = 1'b1;
    cfg_byte   = 3'd0;
    cfg_value  = {2'b00, c[9:8], 2'b00, s[9:8]};
    tick();
    cfg_byte  = 3'd1;
    cfg_value = s[7:0];
    tick();
    cfg_byte  = 3'd5;  // ignored code must not disturb the holding register
    cfg_value = 8'hFF;
    tick();
    cfg_byte  = 3'd2;
    cfg_value = c[7:0];
    tick();
    cfg_enable   = 1'b0;
    ref_start[n] = s;
    ref_count[n] = c;
  endtask

  task automatic fire(input int n, output int acc);
    axon_addr = n[7:0];
    axon_vld  = 1'b1;
    acc       = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (axon_rdy) break;
    end
    chk("fire_accept", int'(axon_rdy), 1);
    if (axon_rdy) begin
      acc = cyc;
      for (int i = 0; i < ref_count[n]; i++) exp_q.push_back((ref_start[n] + i) % 1024);
    end
    @(posedge clk);
    #1 axon_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 1000; k++) begin
      if (exp_q.size() == 0 && !syn_vld) break;
      @(negedge clk);
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic count_vld(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (syn_vld) c++;
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 256; i++) begin
      ref_start[i] = 0;
      ref_count[i] = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc3, first, found, nv, hold_exp;
    zero_model();
    enable    = 1'b1;
    rdy_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_syn_vld", int'(syn_vld), 0);
    chk("rst_syn_addr", int'(syn_addr), 0);
    chk("rst_axon_rdy", int'(axon_rdy), 0);
    chk("rst_step_done", int'(step_done), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    tick();
    reset = 1'b0;

    // clear_config walk: clear_done in the 257th cycle of the hold
    clear_config = 1'b1;
    first = -1;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      if (clear_done && first < 0) first = k;
    end
    chk("clear_done_rise", first, 256);
    chk("clear_done_hold", int'(clear_done), 1);
    tick();
    clear_config = 1'b0;
    tick();
    @(negedge clk);
    chk("clear_done_release", int'(clear_done), 0);
    tick();
    fire(5, acc);
    count_vld(8, nv);
    chk("cleared_no_syn", nv, 0);

    // Basic fire: latency and consecutive addresses
    cfg_write(5, 100, 3);
    fire(5, acc);
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      chk($sformatf("t1_vld_at_%0d", k), int'(syn_vld), int'(k >= LAT && k < LAT + 3));
      if (k == LAT) chk("t1_first_addr", int'(syn_addr), 100);
    end
    wait_drain("t1_drain");

    // 10-bit wrap then step_done
    tick();
    cfg_write(7, 1022, 3);
    fire(7, acc);
    wait_drain("t2_drain");
    @(negedge clk);
    chk("t2_step_done", int'(step_done), 1);

    // count 0: dropped, ready again quickly
    tick();
    cfg_write(9, 40, 0);
    fire(9, acc);
    found = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (axon_rdy && found == 0) found = k;
    end
    chk("t3_rdy_back", int'(found != 0), 1);
    count_vld(6, nv);
    chk("t3_no_syn", nv, 0);

    // syn_rdy low for 4 cycles mid-fire
    tick();
    cfg_write(11, 500, 6);
    fire(11, acc);
    tick();
    tick();
    rdy_force = 1'b0;
    hold_exp  = 500 + 3 - LAT;
    repeat (4) begin
      @(negedge clk);
      chk("t4_stall_vld", int'(syn_vld), 1);
      chk("t4_stall_addr", int'(syn_addr), hold_exp);
    end
    tick();
    rdy_force = 1'b1;
    wait_drain("t4_drain");

    // enable falling mid-fire does not abort
    tick();
    fire(11, acc);
    repeat (LAT - 1) tick();
    enable = 1'b0;
    wait_drain("en_drop_drain");
    @(negedge clk);
    chk("en_drop_step_done", int'(step_done), 0);
    tick();
    enable = 1'b1;

    // config rewrite during send affects only later fires
    tick();
    cfg_write(30, 200, 5);
    fire(30, acc);
    repeat (LAT - 1) tick();
    cfg_write(30, 900, 2);
    wait_drain("cfg_mid_drain");
    tick();
    fire(30, acc);
    wait_drain("cfg_new_drain");

    // clear_act aborts in-flight fire
    tick();
    cfg_write(20, 300, 50);
    fire(20, acc);
    repeat (LAT + 3) tick();
    clear_act = 1'b1;
    @(posedge clk);
    #1 clear_act = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("ca_syn_vld", int'(syn_vld), 0);
    chk("ca_clear_done", int'(clear_done), 1);
    chk("ca_step_done", int'(step_done), 1);
    @(negedge clk);
    chk("ca_clear_done_fall", int'(clear_done), 0);

    // reset mid-fire abandons the rest
    tick();
    fire(20, acc);
    repeat (LAT + 5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_syn_vld", int'(syn_vld), 0);
    chk("rst_mid_syn_addr", int'(syn_addr), 0);

    // randomized fires with random back-pressure
    tick();
    for (int n = 40; n < 48; n++) cfg_write(n, $urandom_range(0, 1023), $urandom_range(0, 8));
    cfg_write(48, 1020, 8);
    rand_rdy = 1'b1;
    for (int t = 0; t < 30; t++) fire($urandom_range(40, 48), acc);
    wait_drain("rand_drain");
    rand_rdy = 1'b0;

`ifdef UCASPIAN_AXON_FIFO_EN
    // back-to-back accepts while the first fire is sending
    tick();
    cfg_write(1, 10, 4);
    cfg_write(2, 20, 2);
    cfg_write(3, 30, 3);
    last_xfer = -1;
    max_gap   = 0;
    fire(1, acc1);
    fire(2, acc);
    fire(3, acc3);
    chk("fifo_b2b_accept", acc3 - acc1, 2);
    wait_drain("fifo_drain");
    chk("fifo_max_gap", int'(max_gap <= 3), 1);
`endif

    // second clear: every neuron now emits nothing
    tick();
    clear_config = 1'b1;
    repeat (258) tick();
    @(negedge clk);
    chk("clear2_done", int'(clear_done), 1);
    tick();
    clear_config = 1'b0;
    zero_model();
    tick();
    fire(5, acc);
    fire(48, acc);
    count_vld(8, nv);
    chk("clear2_no_syn", nv, 0);
    wait_drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucaspian_axon.md
# ucaspian_axon

Transmit end of the axon→synapse fire interface. Accepts one fire per spiking neuron, looks up that neuron's outgoing synapse range (start address, fan-out count) in a 256-entry configuration RAM, and emits one `syn_addr` per synapse on the `syn_addr`/`syn_vld`/`syn_rdy` handshake that feeds `ucaspian_synapse`. It sits between the neuron unit and the synapse unit and takes part in the step-done and clear protocols.

## Interface
- `FIFO_DEPTH`, 4: depth of the input fire FIFO. Power of two. Used only when the FIFO is compiled in.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run enable.
- `clear_act`  in  1  clear activity: abort any in-flight fire.
- `clear_config`  in  1  zero the configuration RAM.
- `clear_done`  out  1  clear complete.
- `step_done`  out  1  no fires held, pending, or in flight.
- `cfg_addr`  in  8  neuron index.
- `cfg_value`  in  8  configuration byte.
- `cfg_byte`  in  3  byte select.
- `cfg_enable`  in  1  configuration write strobe.
- `axon_addr`  in  8  id of the firing neuron.
- `axon_vld`  in  1  fire valid from the neuron unit.
- `axon_rdy`  out  1  fire accept.
- `syn_addr`  out  10  synapse address.
- `syn_vld`  out  1  synapse fire valid.
- `syn_rdy`  in  1  synapse ready.

## Operation
- Configuration RAM: 256 × 20 bits, holding {start[9:0], count[9:0]}.
- Configuration writes, applied only when `cfg_enable` is high:
  - `cfg_byte` 0: load holding register from `cfg_value`. Bits [1:0] become start[9:8]; bits [5:4] become count[9:8].
  - `cfg_byte` 1: load start[7:0] into the holding register.
  - `cfg_byte` 2: write {start, count} to `cfg_addr`, with count[7:0] = `cfg_value`.
  - Other `cfg_byte` values are ignored.
- `clear_config`:
  - Walks addresses 0..255, writing 0 to one address per cycle.
  - `clear_done` goes high the cycle after address 255 is written. It stays high while `clear_config` is held.
  - Configuration writes are ignored during the walk.
- `clear_act`:
  - Forces state to AX_IDLE, drops `syn_vld`, and flushes the FIFO.
  - `clear_done` = 1 on the next cycle.
- State machine:
  - **AX_IDLE**
    - `axon_rdy` = 1 only when `enable` is high and `cfg_enable` is low.
    - On `axon_vld && axon_rdy`: latch `axon_addr`, issue the RAM read, go to AX_LOOKUP.
    - If `enable` is low or `cfg_enable` is high: go to AX_DISABLE.
  - **AX_LOOKUP** (1 cycle)
    - Latch start and count into working registers.
    - Set `syn_addr` = start and offset = 0.
    - count = 0: the fire is dropped; return to AX_IDLE.
    - count ≠ 0: set `syn_vld` = 1 and go to AX_SEND.
  - **AX_SEND**
    - On each `syn_vld && syn_rdy`, offset increments and `syn_addr` = (start + offset) mod 1024. 10-bit wrap: start 1022, count 3 emits 1022, 1023, 0.
    - `syn_vld` stays high across back-to-back transfers.
    - After the transfer for offset = count−1: `syn_vld` = 0, go to AX_IDLE.
    - `enable` falling mid-fire does not abort; the fire completes.
  - **AX_DISABLE**
    - `axon_rdy` = 0, `syn_vld` = 0.
    - Return to AX_IDLE when `enable && !cfg_enable`.
- Configuration writes during AX_SEND modify the RAM only. The in-flight fire uses its latched start and count.
- `step_done` = 1 when state is AX_IDLE, the FIFO is empty, and `axon_vld` is low.

## Timing
- Reset values: `syn_vld` 0, `syn_addr` 0, `axon_rdy` 0, `step_done` 0, `clear_done` 0. State goes to AX_IDLE; working registers and FIFO pointers go to 0.
- Reset mid-fire abandons the remaining synapses.
- Input accept at cycle N puts the first `syn_vld` at N+2.
- With `syn_rdy` held high, a fire with count C occupies cycles N+2 .. N+C+1.
- `syn_addr` holds stable while `syn_vld && !syn_rdy`.
- AX_IDLE is re-entered at the cycle after the last transfer. With the FIFO compiled out, the next accept is no earlier than that cycle.
- Precedence when events coincide: `reset` > `clear_act` > `clear_config` > normal operation.

## Configuration
- `UCASPIAN_AXON_FIFO_EN` defined:
  - Fires pass through a `FIFO_DEPTH`-entry input FIFO.
  - `axon_rdy` = !full && `enable` && !`cfg_enable`, in every state, so accepts continue during AX_SEND.
  - AX_IDLE pops the FIFO head instead of sampling `axon_vld`. This adds one cycle of latency: first `syn_vld` at N+3.
  - Simultaneous push and pop while full is not allowed, because `axon_rdy` is low when full.
- Undefined: no FIFO; `axon_rdy` is asserted only in AX_IDLE as described above.

## Structure
- `ucaspian_pkg` holds:
  - the axon state enum (AX_IDLE, AX_LOOKUP, AX_SEND, AX_DISABLE);
  - widths: NEURON_W = 8, SYN_W = 10, COUNT_W = 10;
  - the cfg_byte codes.
- Sub-module `ucaspian_axon_fifo`: synchronous FIFO with parameter `FIFO_DEPTH`. It is instantiated only under `UCASPIAN_AXON_FIFO_EN`.
- The RAM is inferred in-module with a registered read, so it maps to ice40 BRAM.

## Test plan
- Config neuron 5 = {start 100, count 3}; fire 5 with `syn_rdy` = 1 → `syn_addr` 100, 101, 102 on consecutive cycles; first `syn_vld` at accept+2.
- Config neuron 7 = {start 1022, count 3} → 1022, 1023, 0; then `step_done` = 1.
- Neuron 9 with count 0 → no `syn_vld`; `axon_rdy` high again within 2 cycles.
- `syn_rdy` low for 4 cycles mid-fire → `syn_addr` held constant; no skipped and no duplicated addresses.
- `clear_config` held → `clear_done` rises after 256 cycles; a subsequent fire on any neuron emits nothing.
- FIFO build: fire neurons 1, 2, 3 back-to-back while neuron 1 (count 4) is sending → all 3 accepted; outputs appear in order with no gaps beyond 2 cycles between fires.
